// File: rtl/spu_alu_pkg.sv
// Shared widths, opcode constants and command/result records for the SPU ALU issue path.
package spu_alu_pkg;
  localparam int DATA_W = 8;
  localparam int OP_W   = 6;
  localparam int TAG_W  = 4;

  localparam logic [OP_W-1:0] OP_NOP = 6'd0;
  localparam logic [OP_W-1:0] OP_ADD = 6'd4;
  localparam logic [OP_W-1:0] OP_SUB = 6'd20;
  localparam logic [OP_W-1:0] OP_XOR = 6'd63;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  tag;
  } alu_cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } alu_res_t;
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Decode command channel, ALU operand bus and writeback result channel of alu_issue_ctrl.
interface alu_issue_ctrl_if #(
  parameter int DATA_W = spu_alu_pkg::DATA_W,
  parameter int OP_W   = spu_alu_pkg::OP_W,
  parameter int TAG_W  = spu_alu_pkg::TAG_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [TAG_W-1:0]  cmd_tag;
  logic [OP_W-1:0]   alu_opCode;
  logic [DATA_W-1:0] alu_inA;
  logic [DATA_W-1:0] alu_inB;
  logic [DATA_W-1:0] alu_dataOut;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [TAG_W-1:0]  res_tag;

  // controller side
  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, alu_dataOut, res_ready,
    output cmd_ready, alu_opCode, alu_inA, alu_inB, res_valid, res_data, res_tag
  );

  // decode / ALU / writeback side
  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, alu_dataOut, res_ready,
    input  cmd_ready, alu_opCode, alu_inA, alu_inB, res_valid, res_data, res_tag
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-2 depth, registered occupancy; no write-to-read bypass.
module sync_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_fake,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_fake or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Credit-based ALU issue controller: command FIFO -> ALU -> tagged result FIFO.
// Optional build macro ALU_ISSUE_STATS_EN adds stat_issued / stat_stall counters.
module alu_issue_ctrl #(
  parameter int DATA_W    = spu_alu_pkg::DATA_W,
  parameter int OP_W      = spu_alu_pkg::OP_W,
  parameter int TAG_W     = spu_alu_pkg::TAG_W,
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int ALU_LAT   = 1
) (
  input  logic             clk_fake,
  input  logic             rst_n,
  alu_issue_ctrl_if.master bus,
  output logic             busy
`ifdef ALU_ISSUE_STATS_EN
 ,output logic [31:0]      stat_issued,
  output logic [31:0]      stat_stall
`endif
);
  import spu_alu_pkg::*;

  localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
  localparam int RES_CW = $clog2(RES_DEPTH) + 1;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  tag;
  } cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } res_t;

  cmd_t cmd_in, cmd_head;
  res_t res_in, res_head;
  logic [CMD_CW-1:0] cmd_count;
  logic [RES_CW-1:0] res_count, credits;
  logic cmd_push, cmd_empty, issue, res_pop;
  logic [ALU_LAT-1:0]            vld_pipe;
  logic [ALU_LAT-1:0][TAG_W-1:0] tag_pipe;

  assign cmd_in        = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b, tag: bus.cmd_tag};
  assign bus.cmd_ready = (cmd_count < CMD_CW'(CMD_DEPTH));
  assign cmd_push      = bus.cmd_valid && bus.cmd_ready;
  assign cmd_empty     = (cmd_count == '0);
  // a credit is a reserved result FIFO slot, so a capture can never be refused
  assign issue         = !cmd_empty && (credits != '0);

  assign bus.res_valid = (res_count != '0);
  assign bus.res_data  = res_head.data;
  assign bus.res_tag   = res_head.tag;
  assign res_pop       = bus.res_valid && bus.res_ready;
  assign res_in        = '{data: bus.alu_dataOut, tag: tag_pipe[ALU_LAT-1]};

  assign busy = !cmd_empty || (|vld_pipe) || bus.res_valid;

  sync_fifo #(.W($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk_fake (clk_fake),
    .rst_n    (rst_n),
    .push     (cmd_push),
    .wdata    (cmd_in),
    .pop      (issue),
    .rdata    (cmd_head),
    .count    (cmd_count)
  );

  sync_fifo #(.W($bits(res_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk_fake (clk_fake),
    .rst_n    (rst_n),
    .push     (vld_pipe[ALU_LAT-1]),
    .wdata    (res_in),
    .pop      (res_pop),
    .rdata    (res_head),
    .count    (res_count)
  );

  always_ff @(posedge clk_fake or negedge rst_n) begin
    if (!rst_n) begin
      credits <= RES_CW'(RES_DEPTH);
    end else if (issue && !res_pop) begin
      credits <= credits - RES_CW'(1);
    end else if (!issue && res_pop) begin
      credits <= credits + RES_CW'(1);
    end
  end

  // operands hold between issues; only the opcode returns to NOP
  always_ff @(posedge clk_fake or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_opCode <= OP_W'(OP_NOP);
      bus.alu_inA    <= '0;
      bus.alu_inB    <= '0;
    end else if (issue) begin
      bus.alu_opCode <= cmd_head.op;
      bus.alu_inA    <= cmd_head.a;
      bus.alu_inB    <= cmd_head.b;
    end else begin
      bus.alu_opCode <= OP_W'(OP_NOP);
    end
  end

  always_ff @(posedge clk_fake or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[0] <= issue;
      tag_pipe[0] <= cmd_head.tag;
      for (int i = 1; i < ALU_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  always_ff @(posedge clk_fake or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (issue && (stat_issued != '1)) stat_issued <= stat_issued + 32'd1;
      if (!cmd_empty && (credits == '0) && (stat_stall != '1)) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: vector table, scoreboard and multi-cycle corner sequences.
module tb_alu_issue_ctrl;
  import spu_alu_pkg::*;

  localparam int CMD_DEPTH = 4;
  localparam int RES_DEPTH = 4;
  localparam int ALU_LAT   = 1;

  logic clk_fake = 1'b0;
  logic rst_n    = 1'b0;
  logic busy;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] stat_issued, stat_stall;
`endif

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(
    .CMD_DEPTH (CMD_DEPTH),
    .RES_DEPTH (RES_DEPTH),
    .ALU_LAT   (ALU_LAT)
  ) dut (
    .clk_fake    (clk_fake),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy)
`ifdef ALU_ISSUE_STATS_EN
   ,.stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk_fake = ~clk_fake;

  // reference ALU: combinational on the registered operand bus (ALU_LAT = 1)
  function automatic logic [DATA_W-1:0] alu_f(input logic [OP_W-1:0] op,
                                              input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      default: return a & b;
    endcase
  endfunction

  assign bus.alu_dataOut = alu_f(bus.alu_opCode, bus.alu_inA, bus.alu_inB);

  typedef struct {
    alu_cmd_t          cmd;
    logic [DATA_W-1:0] exp_data;
  } vec_t;

  int nvec = 0, nerr = 0;
  alu_res_t sb[$];
  int n_acc, n_iss, n_pop, n_stall, n_over;
  bit acc_flag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic v, input alu_cmd_t c);
    bus.cmd_valid = v;
    bus.cmd_op    = c.op;
    bus.cmd_a     = c.a;
    bus.cmd_b     = c.b;
    bus.cmd_tag   = c.tag;
  endtask

  // one clock: observe at negedge (scoreboard push/pop), return at posedge+1
  task automatic tick();
    alu_res_t e;
    @(negedge clk_fake);
    if (bus.alu_opCode != OP_NOP) n_iss++;
    if ((n_acc - n_iss > 0) && (n_iss - n_pop >= RES_DEPTH)) n_stall++;
    if (n_iss - n_pop > RES_DEPTH) n_over++;
    acc_flag = 1'b0;
    if (bus.cmd_valid && bus.cmd_ready) begin
      sb.push_back('{data: alu_f(bus.cmd_op, bus.cmd_a, bus.cmd_b), tag: bus.cmd_tag});
      n_acc++;
      acc_flag = 1'b1;
    end
    if (bus.res_valid && bus.res_ready) begin
      n_pop++;
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_result: tag %0h data %0h with nothing pending", bus.res_tag, bus.res_data);
      end else begin
        e = sb.pop_front();
        chk("sb_res_data", bus.res_data, e.data);
        chk("sb_res_tag", bus.res_tag, e.tag);
      end
    end
    @(posedge clk_fake);
    #1;
  endtask

  task automatic reset_apply();
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    #3;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_tag", bus.res_tag, 0);
    chk("rst_alu_opCode", bus.alu_opCode, 0);
    chk("rst_alu_inA", bus.alu_inA, 0);
    chk("rst_alu_inB", bus.alu_inB, 0);
    chk("rst_busy", busy, 0);
`ifdef ALU_ISSUE_STATS_EN
    chk("rst_stat_issued", stat_issued, 0);
    chk("rst_stat_stall", stat_stall, 0);
`endif
    sb.delete();
    n_acc = 0; n_iss = 0; n_pop = 0; n_stall = 0; n_over = 0;
    @(negedge clk_fake);
    rst_n = 1'b1;
    @(posedge clk_fake);
    #1;
  endtask

  vec_t     vecs[4];
  alu_cmd_t ops[10];
  alu_cmd_t idle;
  int k;
  bit seen;

  initial begin
    idle = '0;
    vecs[0] = '{cmd: '{op: OP_ADD, a: 8'd12,  b: 8'd10,  tag: 4'd3}, exp_data: 8'h16};
    vecs[1] = '{cmd: '{op: OP_SUB, a: 8'd5,   b: 8'd9,   tag: 4'hF}, exp_data: 8'hFC};
    vecs[2] = '{cmd: '{op: OP_XOR, a: 8'hA5,  b: 8'hFF,  tag: 4'd0}, exp_data: 8'h5A};
    vecs[3] = '{cmd: '{op: OP_ADD, a: 8'hFF,  b: 8'h01,  tag: 4'd9}, exp_data: 8'h00};
    for (int i = 0; i < 10; i++) begin
      ops[i].op  = (i % 4 == 0) ? OP_XOR : (i % 4 == 2) ? OP_SUB : OP_ADD;
      ops[i].a   = 8'(i * 37 + 5);
      ops[i].b   = 8'(i * 11 + 3);
      ops[i].tag = 4'(i);
    end
    drive_cmd(1'b0, idle);
    bus.res_ready = 1'b0;

    reset_apply();

    // single ops: no bypass, one-cycle issue, result one cycle after issue
    bus.res_ready = 1'b1;
    foreach (vecs[v]) begin
      drive_cmd(1'b1, vecs[v].cmd);
      tick();
      drive_cmd(1'b0, idle);
      chk("accept_no_bypass_opCode", bus.alu_opCode, 0);
      chk("accept_res_valid", bus.res_valid, 0);
      tick();
      chk("issue_opCode", bus.alu_opCode, vecs[v].cmd.op);
      chk("issue_inA", bus.alu_inA, vecs[v].cmd.a);
      chk("issue_inB", bus.alu_inB, vecs[v].cmd.b);
      tick();
      chk("cap_res_valid", bus.res_valid, 1);
      chk("cap_res_data", bus.res_data, vecs[v].exp_data);
      chk("cap_res_tag", bus.res_tag, vecs[v].cmd.tag);
      chk("idle_opCode_nop", bus.alu_opCode, 0);
      chk("idle_inA_hold", bus.alu_inA, vecs[v].cmd.a);
      tick();
      chk("drained_res_valid", bus.res_valid, 0);
      chk("drained_busy", busy, 0);
    end

    // back-to-back: one issue per cycle, results in order on consecutive cycles
    for (int i = 0; i < 6; i++) begin
      drive_cmd(i < 4, (i < 4) ? ops[i] : idle);
      tick();
      if (i < 4) chk("b2b_cmd_ready", bus.cmd_ready, 1);
      if (i >= 1 && i <= 4) chk("b2b_issue_op", bus.alu_opCode, ops[i-1].op);
      if (i >= 2) begin
        chk("b2b_res_valid", bus.res_valid, 1);
        chk("b2b_res_tag", bus.res_tag, ops[i-2].tag);
      end
    end
    drive_cmd(1'b0, idle);
    tick();
    chk("b2b_idle_busy", busy, 0);

    // reset in the middle of a 3-op burst discards everything
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(1'b1, ops[i]);
      tick();
    end
    reset_apply();
    bus.res_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= bus.res_valid;
    end
    chk("post_reset_res_valid", seen, 0);
    chk("post_reset_busy", busy, 0);

    // backpressure: credits cap issue at RES_DEPTH, command FIFO fills behind
    bus.res_ready = 1'b0;
    k = 0;
    for (int t = 0; t < 20; t++) begin
      drive_cmd(k < 10, (k < 10) ? ops[k] : idle);
      tick();
      if (acc_flag) k++;
    end
    chk("bp_accepted", k, RES_DEPTH + CMD_DEPTH);
    chk("bp_issued", n_iss, RES_DEPTH);
    chk("bp_cmd_ready", bus.cmd_ready, 0);
    chk("bp_opCode_nop", bus.alu_opCode, 0);
    chk("bp_res_valid", bus.res_valid, 1);
    chk("bp_busy", busy, 1);
    bus.res_ready = 1'b1;
    for (int t = 0; t < 60 && !(k == 10 && sb.size() == 0 && !busy); t++) begin
      drive_cmd(k < 10, (k < 10) ? ops[k] : idle);
      tick();
      if (acc_flag) k++;
    end
    drive_cmd(1'b0, idle);
    chk("bp_all_accepted", k, 10);
    chk("bp_all_issued", n_iss, 10);
    chk("bp_all_returned", n_pop, 10);
    chk("bp_sb_empty", sb.size(), 0);
    chk("bp_busy_end", busy, 0);
    chk("bp_credit_overrun", n_over, 0);
`ifdef ALU_ISSUE_STATS_EN
    chk("stat_issued", stat_issued, 10);
    chk("stat_stall", stat_stall, n_stall);
`endif

    // full result FIFO + pending command: pop frees a credit, issue next cycle
    bus.res_ready = 1'b0;
    k = 0;
    for (int t = 0; t < 20 && k < 5; t++) begin
      drive_cmd(1'b1, ops[k+5]);
      tick();
      if (acc_flag) k++;
    end
    drive_cmd(1'b0, idle);
    for (int t = 0; t < 6; t++) tick();
    chk("sim_outstanding", n_iss - n_pop, RES_DEPTH);
    chk("sim_opCode_stalled", bus.alu_opCode, 0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("sim_no_issue_on_pop_edge", bus.alu_opCode, 0);
    tick();
    chk("sim_issue_after_pop", bus.alu_opCode, ops[9].op);
    tick();
    tick();
    chk("sim_outstanding_refill", n_iss - n_pop, RES_DEPTH);
    chk("sim_res_valid", bus.res_valid, 1);
    bus.res_ready = 1'b1;
    for (int t = 0; t < 20 && (sb.size() != 0 || busy); t++) tick();
    chk("sim_sb_empty", sb.size(), 0);
    chk("sim_busy_end", busy, 0);
    chk("sim_credit_overrun", n_over, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Real driver for the ALU operand/opcode interface; replaces bench stimulus in the SPU datapath. Accepts tagged operations from decode over valid/ready and buffers them in a small command FIFO. Issues at most one op per cycle to the ALU as opCode/inA/inB, tracks in-flight ops through the fixed ALU latency, captures dataOut and returns tagged results to writeback over valid/ready. Credit-based issue guarantees no result is ever dropped.

Parameters:
DATA_W, 8, operand/result width (matches ALU dataWidth)
OP_W, 6, opcode width
TAG_W, 4, destination tag width
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
RES_DEPTH, 4, result FIFO entries (power of 2, >= ALU_LAT+1)
ALU_LAT, 1, cycles from issue to valid ALU dataOut (>=1)

Ports:
clk_fake  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  decode offers an op
cmd_ready  out  1  command FIFO not full
cmd_op  in  OP_W  opcode
cmd_a  in  DATA_W  operand A
cmd_b  in  DATA_W  operand B
cmd_tag  in  TAG_W  destination tag
alu_opCode  out  OP_W  to ALU opCode
alu_inA  out  DATA_W  to ALU inA
alu_inB  out  DATA_W  to ALU inB
alu_dataOut  in  DATA_W  from ALU dataOut
res_valid  out  1  result available
res_ready  in  1  writeback accepts
res_data  out  DATA_W  result value
res_tag  out  TAG_W  result tag
busy  out  1  any op in command FIFO, in flight, or in result FIFO

Behaviour:
- Reset (async assert, sync-released use): FIFO pointers/counts 0, in-flight shift register cleared, credits = RES_DEPTH; cmd_ready=1, res_valid=0, res_data=0, res_tag=0, alu_opCode=0 (NOP), alu_inA=0, alu_inB=0, busy=0. Reset mid-operation discards all buffered and in-flight ops; no result is emitted afterwards.
- Command accept: handshake when cmd_valid&&cmd_ready; cmd_ready = (cmd_count<CMD_DEPTH), registered-count based, no combinational path from res_ready.
- Issue: fires when command FIFO non-empty and credits>0. Registered: alu_opCode/inA/inB load the head entry on the issue edge; on non-issue cycles drive opCode=0, inA/inB hold. Issued tag enters stage 0 of an ALU_LAT-deep valid+tag shift register; credits decrement.
- Capture: when the shift register's last stage is valid, alu_dataOut is sampled with that tag into the result FIFO on that edge. Throughput 1 op/cycle back to back.
- Issue-to-res_valid latency: ALU_LAT+1 cycles with an empty result FIFO. Cmd-accept-to-issue min 1 cycle.
- Result pop: res_valid = result FIFO non-empty; pop on res_valid&&res_ready; credits increment on pop. Simultaneous issue and pop: credits unchanged.
- Credits never exceed RES_DEPTH and never go negative; result FIFO therefore never overflows.
- Simultaneous push and pop on full command FIFO: push refused (cmd_ready=0); pop proceeds. Push and pop on empty FIFO: no bypass, entry issues next cycle.
- Pointers wrap modulo depth; count widths $clog2(depth)+1.
- Ordering: results return strictly in issue order.

Optional Feature:
ALU_ISSUE_STATS_EN: when defined, adds outputs stat_issued (32b, count of issues) and stat_stall (32b, cycles with command FIFO non-empty but credits==0); both reset to 0, saturate at all-ones. When undefined, these ports and counters do not exist; all other behaviour identical.

Decomposition:
- Package spu_alu_pkg: OP_W, DATA_W defaults, opcode constants (OP_NOP=0 plus codes used in test, 4 and 20, 63), typedef alu_cmd_t {op, a, b, tag}, typedef alu_res_t {data, tag}.
- One sub-module: sync_fifo (parameterised width/depth, used for both command and result FIFOs).

Test Plan:
- Reset: rst_n low mid-burst of 3 ops -> all outputs at reset values immediately, no res_valid after release, busy=0.
- Single op: op=4, a=12, b=10, tag=3, res_ready=1 -> alu_opCode=4 one cycle after accept, res_valid with tag=3 and captured dataOut ALU_LAT+1 cycles after issue.
- Back-to-back: ops 63,4,20,4 with tags 0..3 every cycle, res_ready=1 -> one issue per cycle, results tags 0,1,2,3 in order on consecutive cycles.
- Backpressure: res_ready=0, push 10 ops -> exactly RES_DEPTH issued, then alu_opCode=0, cmd_ready falls after CMD_DEPTH more; res_ready=1 -> all 10 drain in order, none lost.
- Simultaneous: full result FIFO, same-cycle pop and pending command -> issue next cycle, credits never exceed 4.
- ALU_ISSUE_STATS_EN build: backpressure scenario -> stat_issued=10 at drain, stat_stall equals stalled cycle count.
